// File: rtl/led_loop_pkg.sv
// Shared encodings and default sizes for the LED loop sequencer.
package led_loop_pkg;

   localparam int LED_N_DEF = 8;
   localparam int CNT_W_DEF = 24;

   localparam logic [1:0] MODE_SHL   = 2'd0;
   localparam logic [1:0] MODE_SHR   = 2'd1;
   localparam logic [1:0] MODE_PING  = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      PAUSE = 2'd3
   } state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Prescale counter: counts while enabled and strobes o_tick on the last count
// of each period, wrapping to zero on that same edge.
module led_tick_gen #(
   parameter int CNT_W = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_div_eff,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_count;
   logic             w_hit;

   // i_div_eff is never zero, so the period end is always reachable.
   assign w_hit  = (r_count == (i_div_eff - CNT_W'(1)));
   assign o_tick = i_en & w_hit;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_hit ? '0 : (r_count + CNT_W'(1));
      end
   end

endmodule

// File: rtl/led_loop_sequencer.sv
// Running-light controller: config latch, IDLE/LOAD/RUN/PAUSE FSM and the
// LED pattern register, stepped by the prescale tick.
//
// Config handshake: a transfer happens at a rising edge where Cfg_Valid and
// Cfg_Ready are both high and Clear is low; Cfg_Ready drops only in LOAD.
module led_loop_sequencer
   import led_loop_pkg::*;
#(
   parameter int LED_N = LED_N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             CLK_In,
   input  logic             RST,
   input  logic             Cfg_Valid,
   output logic             Cfg_Ready,
   input  logic [1:0]       Cfg_Mode,
   input  logic [CNT_W-1:0] Cfg_Div,
   input  logic             Run_En,
   input  logic             Clear,
   output logic [LED_N-1:0] LED,
   output logic             Tick,
   output logic             Busy,
   output logic [1:0]       Dbg_State
);

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_mode;
   logic [CNT_W-1:0] r_div;
   logic             r_dir;
   logic [LED_N-1:0] r_led;
   logic [LED_N-1:0] w_led_adv;
   logic             w_dir_adv;
   logic             w_hs;
   logic             w_run_go;
   logic             w_cnt_clr;
   logic             w_tick;

   function automatic logic [LED_N-1:0] init_pat(input logic [1:0] m);
      case (m)
         MODE_SHR:   init_pat = {1'b1, {(LED_N-1){1'b0}}};
         MODE_BLINK: init_pat = '1;
         default:    init_pat = LED_N'(1);
      endcase
   endfunction

   assign Cfg_Ready = (r_state != LOAD);
   assign w_hs      = Cfg_Valid & Cfg_Ready & ~Clear;
   // Clear and a new config both pre-empt the pending step in the same cycle.
   assign w_run_go  = (r_state == RUN) & Run_En & ~Clear & ~w_hs;
   assign w_cnt_clr = Clear | w_hs | (r_state == IDLE) | (r_state == LOAD);

   led_tick_gen #(.CNT_W(CNT_W)) u_tick (
      .i_clk     (CLK_In),
      .i_rst_n   (RST),
      .i_en      (w_run_go),
      .i_clr     (w_cnt_clr),
      .i_div_eff (r_div),
      .o_tick    (w_tick)
   );

   always_ff @(posedge CLK_In) begin
      if (!RST) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (Clear) begin
         w_next = IDLE;
      end else if (w_hs) begin
         w_next = LOAD;
      end else begin
         case (r_state)
            LOAD:    w_next = Run_En ? RUN : PAUSE;
            RUN:     if (!Run_En) w_next = PAUSE;
            PAUSE:   if (Run_En) w_next = RUN;
            default: w_next = r_state;
         endcase
      end
   end

   // r_dir: 0 = moving toward the MSB, 1 = moving toward bit 0.
   always_comb begin
      w_led_adv = r_led;
      w_dir_adv = r_dir;
      case (r_mode)
         MODE_SHL: w_led_adv = {r_led[LED_N-2:0], r_led[LED_N-1]};
         MODE_SHR: w_led_adv = {r_led[0], r_led[LED_N-1:1]};
         MODE_PING: begin
            if (!r_dir) begin
               w_led_adv = r_led << 1;
               if (w_led_adv[LED_N-1]) w_dir_adv = 1'b1;
            end else begin
               w_led_adv = r_led >> 1;
               if (w_led_adv[0]) w_dir_adv = 1'b0;
            end
         end
         default: w_led_adv = ~r_led;
      endcase
   end

   always_ff @(posedge CLK_In) begin
      if (!RST) begin
         r_led  <= '0;
         r_dir  <= 1'b0;
         r_mode <= MODE_SHL;
         r_div  <= CNT_W'(1);
      end else if (Clear) begin
         r_led <= '0;
         r_dir <= 1'b0;
      end else if (w_hs) begin
         r_mode <= Cfg_Mode;
         r_div  <= (Cfg_Div == '0) ? CNT_W'(1) : Cfg_Div;
      end else if (r_state == LOAD) begin
         r_led <= init_pat(r_mode);
         r_dir <= 1'b0;
      end else if (w_tick) begin
         r_led <= w_led_adv;
         r_dir <= w_dir_adv;
      end
   end

   assign LED       = r_led;
   assign Tick      = w_tick;
   assign Busy      = (r_state != IDLE);
   assign Dbg_State = r_state;

endmodule

// File: tb/tb_led_loop_sequencer.sv
// Directed bench for led_loop_sequencer with a queue-based LED scoreboard.
module tb_led_loop_sequencer;
   import led_loop_pkg::*;

   localparam int LED_N = 8;
   localparam int CNT_W = 24;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             RST;
   logic             Cfg_Valid;
   logic             Cfg_Ready;
   logic [1:0]       Cfg_Mode;
   logic [CNT_W-1:0] Cfg_Div;
   logic             Run_En;
   logic             Clear;
   logic [LED_N-1:0] LED;
   logic             Tick;
   logic             Busy;
   logic [1:0]       Dbg_State;

   always #5 clk = ~clk;

   led_loop_sequencer #(.LED_N(LED_N), .CNT_W(CNT_W)) dut (
      .CLK_In    (clk),
      .RST       (RST),
      .Cfg_Valid (Cfg_Valid),
      .Cfg_Ready (Cfg_Ready),
      .Cfg_Mode  (Cfg_Mode),
      .Cfg_Div   (Cfg_Div),
      .Run_En    (Run_En),
      .Clear     (Clear),
      .LED       (LED),
      .Tick      (Tick),
      .Busy      (Busy),
      .Dbg_State (Dbg_State)
   );

   // ---------------- scoreboard state ----------------
   logic [LED_N-1:0] exp_q[$];
   int checks   = 0;
   int errors   = 0;
   int exp_gap  = 0;
   int tick_cnt = 0;
   int cyc      = 0;
   int prev_cyc = 0;
   logic have_prev = 1'b0;
   logic pend      = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // An output event is a Tick or a LOAD cycle; LED after that edge is checked.
   always @(negedge clk) begin
      cyc++;
      if (pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_step actual=%0h required=none", LED);
         end else begin
            chk("sb_led", 32'(LED), 32'(exp_q.pop_front()));
         end
      end
      if (RST === 1'b1 && Tick === 1'b1) begin
         tick_cnt++;
         if (have_prev && exp_gap > 0) chk("tick_gap", 32'(cyc - prev_cyc), 32'(exp_gap));
         prev_cyc = cyc;
      end
      if (RST === 1'b1 && Cfg_Ready === 1'b0) begin
         prev_cyc  = cyc;
         have_prev = 1'b1;
      end
      pend = (RST === 1'b1) && (Tick === 1'b1 || Cfg_Ready === 1'b0);
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_cfg(input logic [1:0] mode, input logic [CNT_W-1:0] div,
                         input logic [LED_N-1:0] init);
      Cfg_Mode  = mode;
      Cfg_Div   = div;
      Cfg_Valid = 1'b1;
      exp_q.push_back(init);
      step(1);
      Cfg_Valid = 1'b0;
      chk("cfg_ready_in_load", 32'(Cfg_Ready), 32'd0);
      chk("state_load", 32'(Dbg_State), 32'(LOAD));
   endtask

   logic [LED_N-1:0] pp_seq[16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
   int t0;

   initial begin
      RST       = 1'b0;
      Cfg_Valid = 1'b1;
      Cfg_Mode  = MODE_BLINK;
      Cfg_Div   = 24'd7;
      Run_En    = 1'b1;
      Clear     = 1'b0;

      // Reset held with a config offered.
      step(3);
      chk("rst_led", 32'(LED), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_tick", 32'(Tick), 32'd0);
      chk("rst_ready", 32'(Cfg_Ready), 32'd1);
      Cfg_Valid = 1'b0;
      RST       = 1'b1;
      step(2);
      chk("post_rst_idle", 32'(Dbg_State), 32'(IDLE));
      chk("post_rst_led", 32'(LED), 32'd0);

      // Shift-left, period 4.
      exp_gap = 4;
      t0 = tick_cnt;
      do_cfg(MODE_SHL, 24'd4, 8'h01);
      for (int i = 1; i <= 8; i++) exp_q.push_back(8'(1 << (i % 8)));
      step(33);
      Run_En = 1'b0;
      step(2);
      chk("shl_drain", 32'(exp_q.size()), 32'd0);
      chk("shl_ticks", 32'(tick_cnt - t0), 32'd8);

      // Ping-pong, period 1 (div 1).
      exp_gap = 1;
      Run_En  = 1'b1;
      do_cfg(MODE_PING, 24'd1, 8'h01);
      for (int i = 0; i < 16; i++) exp_q.push_back(pp_seq[i]);
      step(17);
      Run_En = 1'b0;
      step(2);
      chk("ping_drain", 32'(exp_q.size()), 32'd0);

      // Shift-right, period 10, pause at count 6.
      exp_gap = 10;
      Run_En  = 1'b1;
      do_cfg(MODE_SHR, 24'd10, 8'h80);
      exp_q.push_back(8'h40);
      step(17);
      Run_En  = 1'b0;
      exp_gap = 0;
      t0 = tick_cnt;
      step(20);
      chk("pause_led", 32'(LED), 32'h40);
      chk("pause_state", 32'(Dbg_State), 32'(PAUSE));
      chk("pause_no_tick", 32'(tick_cnt - t0), 32'd0);
      exp_q.push_back(8'h20);
      Run_En = 1'b1;
      step(3);
      chk("resume_tick_early", 32'(Tick), 32'd0);
      step(1);
      chk("resume_tick", 32'(Tick), 32'd1);
      step(1);
      chk("resume_led", 32'(LED), 32'h20);
      Run_En = 1'b0;
      step(1);

      // Blink period 5, then reconfigure in RUN to shift-left with div 0.
      exp_gap = 5;
      Run_En  = 1'b1;
      do_cfg(MODE_BLINK, 24'd5, 8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      step(12);
      chk("blink_state_run", 32'(Dbg_State), 32'(RUN));
      exp_gap = 1;
      do_cfg(MODE_SHL, 24'd0, 8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h04);
      exp_q.push_back(8'h08);
      step(4);
      Run_En = 1'b0;
      step(1);
      chk("reconfig_drain", 32'(exp_q.size()), 32'd0);
      chk("reconfig_led", 32'(LED), 32'h08);

      // Clear with a simultaneous config offer while running.
      exp_gap = 0;
      Run_En  = 1'b1;
      step(1);
      chk("pre_clear_tick", 32'(Tick), 32'd1);
      Clear     = 1'b1;
      Cfg_Valid = 1'b1;
      Cfg_Mode  = MODE_SHR;
      Cfg_Div   = 24'd9;
      #1;
      chk("clear_tick_kill", 32'(Tick), 32'd0);
      chk("clear_ready", 32'(Cfg_Ready), 32'd1);
      step(1);
      chk("clear_led", 32'(LED), 32'd0);
      chk("clear_busy", 32'(Busy), 32'd0);
      chk("clear_state", 32'(Dbg_State), 32'(IDLE));
      Clear     = 1'b0;
      Cfg_Valid = 1'b0;
      Run_En    = 1'b0;
      step(2);
      chk("clear_still_idle", 32'(Busy), 32'd0);

      // Config from IDLE with Run_En low lands in PAUSE.
      do_cfg(MODE_PING, 24'd3, 8'h01);
      step(2);
      chk("idle_cfg_pause", 32'(Dbg_State), 32'(PAUSE));
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
